// File: rtl/x4_spi_pkg.sv
// Shared types and frame helpers for the X4 multi-channel SPI master.
// Optional ISR latch in the top is enabled with `define X4_ISR_LATCH_EN.
package x4_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_DONE     = 3'd4
  } x4_state_e;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int RD_BIT  = 15;

  function automatic int div_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  // Reads carry a zero data byte so the slave sees a clean read frame.
  function automatic logic [FRAME_W-1:0] build_frame(input logic rd,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] wdata);
    return {rd, addr, rd ? {DATA_W{1'b0}} : wdata};
  endfunction

endpackage

// File: rtl/x4_spi_shift_engine.sv
// Single shared SPI mode-0 shift engine: divider, bit counter, TX/RX shift registers.
// Exposes next-cycle SCLK/MOSI so the top can register them per channel.
module x4_spi_shift_engine
  import x4_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic               miso,
  input  logic [FRAME_W-1:0] frame,
  output logic               sclk_nxt,
  output logic               mosi_nxt,
  output logic               last,
  output logic [DATA_W-1:0]  rx_data
);

  localparam int DIV_W = div_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt_r, div_cnt_s;
  logic [3:0]         bit_cnt_r, bit_cnt_s;
  logic               phase_r, phase_s;
  logic [FRAME_W-1:0] shreg_r, shreg_s;
  logic [DATA_W-1:0]  rx_r, rx_s;
  logic               div_end_s;

  // Next-state logic: phase_r is the SCLK level; MOSI is the shift register MSB.
  always_comb begin
    div_cnt_s = div_cnt_r;
    bit_cnt_s = bit_cnt_r;
    phase_s   = phase_r;
    shreg_s   = shreg_r;
    rx_s      = rx_r;
    div_end_s = (div_cnt_r == DIV_MAX);
    if (load) begin
      div_cnt_s = {DIV_W{1'b0}};
      bit_cnt_s = 4'd0;
      phase_s   = 1'b0;
      shreg_s   = frame;
      rx_s      = {DATA_W{1'b0}};
    end else if (en) begin
      if (div_end_s) begin
        div_cnt_s = {DIV_W{1'b0}};
        if (!phase_r) begin
          phase_s = 1'b1;
          rx_s    = {rx_r[DATA_W-2:0], miso};
        end else begin
          // Falling edge: present the next bit; after bit 15 this drains MOSI to 0.
          phase_s = 1'b0;
          shreg_s = {shreg_r[FRAME_W-2:0], 1'b0};
          if (bit_cnt_r != 4'd15) begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
        end
      end else begin
        div_cnt_s = div_cnt_r + DIV_W'(1);
      end
    end else begin
      div_cnt_s = div_cnt_r;
    end
    last     = en & div_end_s & phase_r & (bit_cnt_r == 4'd15);
    sclk_nxt = phase_s;
    mosi_nxt = shreg_s[FRAME_W-1];
  end

  // Engine state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= 4'd0;
      phase_r   <= 1'b0;
      shreg_r   <= {FRAME_W{1'b0}};
      rx_r      <= {DATA_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      phase_r   <= phase_s;
      shreg_r   <= shreg_s;
      rx_r      <= rx_s;
    end
  end

  assign rx_data = rx_r;

endmodule

// File: rtl/x4_multi_spi_ctrl.sv
// N-channel X4 SPI master: command FSM, channel mux/demux around one shift engine.
// `define X4_ISR_LATCH_EN adds per-channel synchronised ISR edge latches.
module x4_multi_spi_ctrl
  import x4_spi_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CH_W    = 3,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic              cmd_rd,
  input  logic [6:0]        cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [CH_W-1:0]   rsp_ch,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [N_CH-1:0]   spi_sclk,
  output logic [N_CH-1:0]   spi_mosi,
  output logic [N_CH-1:0]   spi_cs_n,
  input  logic [N_CH-1:0]   spi_miso
`ifdef X4_ISR_LATCH_EN
  ,
  input  logic [N_CH-1:0]   x4_isr,
  input  logic [N_CH-1:0]   isr_clr,
  output logic [N_CH-1:0]   isr_pend
`endif
);

  localparam int DIV_W = div_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [CH_W:0]    N_CH_C  = (CH_W + 1)'(N_CH);

  x4_state_e          state_r;
  logic [DIV_W-1:0]   ph_cnt_r;
  logic [CH_W-1:0]    ch_r;
  logic               rd_r;
  logic               err_r;
  logic [N_CH-1:0]    sel_r;
  logic [N_CH-1:0]    cs_n_r;
  logic [N_CH-1:0]    sclk_r;
  logic [N_CH-1:0]    mosi_r;
  logic               rsp_valid_r;
  logic               rsp_err_r;
  logic [CH_W-1:0]    rsp_ch_r;
  logic [DATA_W-1:0]  rsp_rdata_r;

  logic               hs_s;
  logic               ch_bad_s;
  logic               load_s;
  logic               shift_en_s;
  logic               miso_s;
  logic               sclk_nxt_s;
  logic               mosi_nxt_s;
  logic               last_s;
  logic [FRAME_W-1:0] frame_s;
  logic [N_CH-1:0]    onehot_s;
  logic [DATA_W-1:0]  rx_data_s;

  assign cmd_ready  = (state_r == ST_IDLE);
  assign busy       = ~cmd_ready;
  assign hs_s       = cmd_valid & cmd_ready;
  assign ch_bad_s   = ({1'b0, cmd_ch} >= N_CH_C);
  assign load_s     = hs_s & ~ch_bad_s;
  assign shift_en_s = (state_r == ST_SHIFT);
  assign miso_s     = |(spi_miso & sel_r);
  assign frame_s    = build_frame(cmd_rd, cmd_addr, cmd_wdata);
  assign onehot_s   = N_CH'(1'b1) << cmd_ch;

  x4_spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .en       (shift_en_s),
    .miso     (miso_s),
    .frame    (frame_s),
    .sclk_nxt (sclk_nxt_s),
    .mosi_nxt (mosi_nxt_s),
    .last     (last_s),
    .rx_data  (rx_data_s)
  );

  // Command FSM with registered pins and response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ph_cnt_r    <= {DIV_W{1'b0}};
      ch_r        <= {CH_W{1'b0}};
      rd_r        <= 1'b0;
      err_r       <= 1'b0;
      sel_r       <= {N_CH{1'b0}};
      cs_n_r      <= {N_CH{1'b1}};
      sclk_r      <= {N_CH{1'b0}};
      mosi_r      <= {N_CH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_ch_r    <= {CH_W{1'b0}};
      rsp_rdata_r <= {DATA_W{1'b0}};
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            ch_r     <= cmd_ch;
            rd_r     <= cmd_rd;
            ph_cnt_r <= {DIV_W{1'b0}};
            if (ch_bad_s) begin
              // Out-of-range channel: answer with an error, never touch the pins.
              err_r   <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              err_r   <= 1'b0;
              sel_r   <= onehot_s;
              cs_n_r  <= ~onehot_s;
              mosi_r  <= onehot_s & {N_CH{frame_s[RD_BIT]}};
              state_r <= ST_CS_SETUP;
            end
          end
        end
        ST_CS_SETUP: begin
          if (ph_cnt_r == DIV_MAX) begin
            ph_cnt_r <= {DIV_W{1'b0}};
            state_r  <= ST_SHIFT;
          end else begin
            ph_cnt_r <= ph_cnt_r + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          sclk_r <= sel_r & {N_CH{sclk_nxt_s}};
          mosi_r <= sel_r & {N_CH{mosi_nxt_s}};
          if (last_s) begin
            state_r <= ST_CS_HOLD;
          end
        end
        ST_CS_HOLD: begin
          if (ph_cnt_r == DIV_MAX) begin
            ph_cnt_r <= {DIV_W{1'b0}};
            cs_n_r   <= {N_CH{1'b1}};
            mosi_r   <= {N_CH{1'b0}};
            state_r  <= ST_DONE;
          end else begin
            ph_cnt_r <= ph_cnt_r + DIV_W'(1);
          end
        end
        ST_DONE: begin
          rsp_valid_r <= 1'b1;
          rsp_ch_r    <= ch_r;
          rsp_err_r   <= err_r;
          rsp_rdata_r <= (rd_r & ~err_r) ? rx_data_s : {DATA_W{1'b0}};
          sel_r       <= {N_CH{1'b0}};
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi_cs_n  = cs_n_r;
  assign spi_sclk  = sclk_r;
  assign spi_mosi  = mosi_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_ch    = rsp_ch_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

`ifdef X4_ISR_LATCH_EN
  logic [N_CH-1:0] isr_s1_r, isr_s2_r, isr_s3_r, isr_pend_r;

  // Two-flop synchroniser, rising-edge detect; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isr_s1_r   <= {N_CH{1'b0}};
      isr_s2_r   <= {N_CH{1'b0}};
      isr_s3_r   <= {N_CH{1'b0}};
      isr_pend_r <= {N_CH{1'b0}};
    end else begin
      isr_s1_r   <= x4_isr;
      isr_s2_r   <= isr_s1_r;
      isr_s3_r   <= isr_s2_r;
      isr_pend_r <= (isr_pend_r & ~isr_clr) | (isr_s2_r & ~isr_s3_r);
    end
  end

  assign isr_pend = isr_pend_r;
`endif

endmodule

// File: tb/tb_x4_multi_spi_ctrl.sv
// Scoreboard bench for x4_multi_spi_ctrl (N_CH=4, CLK_DIV=2) with per-channel SPI slave models.
module tb_x4_multi_spi_ctrl;

  localparam int N_CH    = 4;
  localparam int CH_W    = 3;
  localparam int CLK_DIV = 2;
  localparam int LAT     = 34 * CLK_DIV + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [CH_W-1:0] cmd_ch;
  logic            cmd_rd;
  logic [6:0]      cmd_addr;
  logic [7:0]      cmd_wdata;
  logic            rsp_valid;
  logic [CH_W-1:0] rsp_ch;
  logic [7:0]      rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic [N_CH-1:0] spi_sclk;
  logic [N_CH-1:0] spi_mosi;
  logic [N_CH-1:0] spi_cs_n;
  logic [N_CH-1:0] spi_miso;
`ifdef X4_ISR_LATCH_EN
  logic [N_CH-1:0] x4_isr;
  logic [N_CH-1:0] isr_clr;
  logic [N_CH-1:0] isr_pend;
`endif

  x4_multi_spi_ctrl #(.N_CH(N_CH), .CH_W(CH_W), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_rd    (cmd_rd),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ch    (rsp_ch),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_miso  (spi_miso)
`ifdef X4_ISR_LATCH_EN
    ,
    .x4_isr    (x4_isr),
    .isr_clr   (isr_clr),
    .isr_pend  (isr_pend)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  slave_data [4] = '{8'h5A, 8'hC3, 8'h99, 8'h3C};
  logic [15:0] cap_frame [4];
  int          cap_clks [4];

  // Mode-0 slave per channel: drives MISO from CS fall, shifts on SCLK fall, captures MOSI on rise.
  for (genvar g = 0; g < N_CH; g++) begin : g_sl
    logic [15:0] sl_tx = 16'h0000;
    logic [15:0] sl_rx = 16'h0000;
    int          sl_clks = 0;
    logic        cs_q = 1'b1;
    logic        sclk_q = 1'b0;
    always @(spi_cs_n[g], spi_sclk[g]) begin
      if (cs_q && !spi_cs_n[g]) begin
        sl_tx   = {8'h00, slave_data[g]};
        sl_rx   = 16'h0000;
        sl_clks = 0;
      end else if (!sclk_q && spi_sclk[g]) begin
        sl_rx   = {sl_rx[14:0], spi_mosi[g]};
        sl_clks = sl_clks + 1;
      end else if (sclk_q && !spi_sclk[g]) begin
        sl_tx = {sl_tx[14:0], 1'b0};
      end
      cs_q   = spi_cs_n[g];
      sclk_q = spi_sclk[g];
    end
    assign spi_miso[g]  = sl_tx[15];
    assign cap_frame[g] = sl_rx;
    assign cap_clks[g]  = sl_clks;
  end

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [7:0]      rdata;
    logic            err;
    logic [15:0]     frame;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic pin_act = 1'b0;
  logic idle_viol = 1'b0;
  int   hi_run = 0;
  int   last_gap = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pin sanity, response compare (pop) and handshake capture (push), all at negedge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((spi_cs_n & (spi_sclk | spi_mosi)) != 4'h0) idle_viol = 1'b1;
        if ($countones(~spi_cs_n) > 1) idle_viol = 1'b1;
        if (spi_cs_n != 4'hF || spi_sclk != 4'h0) pin_act = 1'b1;
        if (&spi_cs_n) begin
          hi_run++;
        end else begin
          if (hi_run > 0) last_gap = hi_run;
          hi_run = 0;
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_rsp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq("rsp_ch", rsp_ch, e.ch);
            check_eq("rsp_err", rsp_err, e.err);
            check_eq("rsp_rdata", rsp_rdata, e.rdata);
            check_eq("latency", cyc, e.cyc);
            check_eq("idle_pins", idle_viol, 1'b0);
            if (e.err) begin
              check_eq("err_no_pins", pin_act, 1'b0);
            end else begin
              check_eq("mosi_frame", cap_frame[e.ch[1:0]], e.frame);
              check_eq("sclk_count", cap_clks[e.ch[1:0]], 16);
            end
          end
        end
        if (cmd_valid && cmd_ready) begin
          e.ch    = cmd_ch;
          e.err   = (cmd_ch >= 3'd4);
          e.frame = {cmd_rd, cmd_addr, cmd_rd ? 8'h00 : cmd_wdata};
          e.rdata = (cmd_rd && !e.err) ? slave_data[cmd_ch[1:0]] : 8'h00;
          e.cyc   = cyc + 1 + (e.err ? 1 : LAT);
          exp_q.push_back(e);
          pin_act   = 1'b0;
          idle_viol = 1'b0;
        end
      end
    end
  endtask

  task automatic send(input int ch, input logic rd, input logic [6:0] addr, input logic [7:0] wd);
    logic ok;
    ok        = 1'b0;
    cmd_ch    = 3'(ch);
    cmd_rd    = rd;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    tick();
    cmd_valid = 1'b0;
    if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    tick();
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_ch    = 3'd0;
    cmd_rd    = 1'b0;
    cmd_addr  = 7'h00;
    cmd_wdata = 8'h00;
`ifdef X4_ISR_LATCH_EN
    x4_isr  = 4'h0;
    isr_clr = 4'h0;
`endif
    fork
      monitor();
    join_none
    repeat (3) tick();
    check_eq("rst_cs_n", spi_cs_n, 4'hF);
    check_eq("rst_sclk", spi_sclk, 4'h0);
    check_eq("rst_mosi", spi_mosi, 4'h0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_rdata", rsp_rdata, 8'h00);
    check_eq("rst_ready", cmd_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
`ifdef X4_ISR_LATCH_EN
    check_eq("rst_isr_pend", isr_pend, 4'h0);
`endif
    rst_n = 1'b1;
    tick();

    send(1, 1'b0, 7'h12, 8'hA5);
    check_eq("busy_in_frame", busy, 1'b1);
    check_eq("cs1_low", spi_cs_n, 4'hD);
    drain();

    send(3, 1'b1, 7'h05, 8'hFF);
    drain();

    send(5, 1'b1, 7'h22, 8'h00);
    drain();

    // Back-to-back: second command waits for IDLE, CS must go high between frames.
    send(0, 1'b1, 7'h7F, 8'h00);
    last_gap = 0;
    send(2, 1'b0, 7'h40, 8'h11);
    @(negedge clk);
    #1;
    check_eq("cs_gap", (last_gap >= 1), 1'b1);
    drain();

    // Reset during bit 7 of a read on channel 0.
    send(0, 1'b1, 7'h21, 8'h00);
    for (int i = 0; i < 300 && cap_clks[0] < 8; i++) @(negedge clk);
    check_eq("reach_bit7", (cap_clks[0] >= 8), 1'b1);
    rst_n = 1'b0;
    tick();
    check_eq("midrst_cs_n", spi_cs_n, 4'hF);
    check_eq("midrst_sclk", spi_sclk, 4'h0);
    check_eq("midrst_ready", cmd_ready, 1'b1);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (80) tick();
    send(2, 1'b1, 7'h33, 8'h00);
    drain();

    for (int k = 0; k < 4; k++) begin
      send($urandom_range(0, 5), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
           8'($urandom_range(0, 255)));
      drain();
    end

`ifdef X4_ISR_LATCH_EN
    x4_isr[2] = 1'b1;
    tick();
    x4_isr[2] = 1'b0;
    tick();
    check_eq("isr_pend_early", isr_pend[2], 1'b0);
    tick();
    check_eq("isr_pend_set", isr_pend[2], 1'b1);
    isr_clr[2] = 1'b1;
    tick();
    isr_clr[2] = 1'b0;
    check_eq("isr_pend_clr", isr_pend[2], 1'b0);
    x4_isr[2] = 1'b1;
    tick();
    x4_isr[2] = 1'b0;
    tick();
    isr_clr[2] = 1'b1;
    tick();
    isr_clr[2] = 1'b0;
    check_eq("isr_set_wins", isr_pend[2], 1'b1);
    tick();
    check_eq("isr_pend_hold", isr_pend, 4'h4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
